// File: rtl/srl_pkg.sv
// Shared helpers for the programmable SRL delay line.
//
// Contents:
//   clog2     - ceiling log2, used to size the length field (AW) from DEPTH
//   depth_ok  - true when a depth is a power of two and at least 2
//   DEFAULT_DEPTH / DEFAULT_DEPTH_OK - the stock 32-deep configuration and
//               its legality check, evaluated at elaboration time
package srl_pkg;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

   localparam int DEFAULT_DEPTH    = 32;
   localparam bit DEFAULT_DEPTH_OK = depth_ok(DEFAULT_DEPTH);

endpackage

// File: rtl/srl_delay_line_if.sv
// Data/control bundle for srl_delay_line.
//
// Signals:
//   ce      shift enable, one word accepted per cycle with ce=1
//   d       input word (WIDTH)
//   len     requested length code (AW); delay = len+1 strobes
//   len_ld  load strobe for len
//   y       registered delayed word (WIDTH)
//   valid   y carries a word accepted since the last reset/length load
//   yc      cascade tap, fixed delay of DEPTH strobes (WIDTH)
//
// Modports: master drives the request side, slave is the delay line itself.
interface srl_delay_line_if
   import srl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 32
);
   localparam int AW = clog2(DEPTH);

   logic             ce;
   logic [WIDTH-1:0] d;
   logic [AW-1:0]    len;
   logic             len_ld;
   logic [WIDTH-1:0] y;
   logic             valid;
   logic [WIDTH-1:0] yc;

   modport master (
      output ce, d, len, len_ld,
      input  y, valid, yc
   );

   modport slave (
      input  ce, d, len, len_ld,
      output y, valid, yc
   );

endinterface

// File: rtl/srl_store.sv
// Reset-free shift array for the SRL delay line. Kept free of any reset
// so synthesis can map it onto SRL primitives.
//
// Ports:
//   clk   rising-edge clock
//   ce    shift enable: mem[0] <= d, mem[i] <= mem[i-1]
//   d     input word
//   addr  tap address into the array
//   tap   mem[addr] (combinational)
//   last  mem[DEPTH-1], the oldest stored word (combinational)
module srl_store
   import srl_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 32,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   input  logic [AW-1:0]    addr,
   output logic [WIDTH-1:0] tap,
   output logic [WIDTH-1:0] last
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (ce) begin
         mem[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign tap  = mem[addr];
   assign last = mem[DEPTH-1];

endmodule

// File: rtl/srl_delay_line.sv
// Programmable-length delay line for DSP datapath alignment.
// Delay from d to y is len_q+1 ce strobes; y is registered and valid flags
// that y carries a word accepted since the last reset or length load.
// yc is a fixed DEPTH-strobe cascade tap straight from storage.
//
// Parameters: WIDTH word width, DEPTH max delay (power of two, >=2),
//             LEN_RST length code applied at reset.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (y, valid, fill, len_q)
//   bus  srl_delay_line_if slave modport (ce, d, len, len_ld, y, valid, yc)
module srl_delay_line
   import srl_pkg::*;
#(
   parameter  int WIDTH   = 4,
   parameter  int DEPTH   = 32,
   parameter  int LEN_RST = DEPTH - 1,
   localparam int AW      = clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   srl_delay_line_if.slave bus
);

   generate
      if (!depth_ok(DEPTH)) begin : g_bad_depth
         $error("srl_delay_line: DEPTH must be a power of two and at least 2");
      end
   endgenerate

   logic [AW-1:0]    len_q;
   logic [AW:0]      fill;
   logic [AW:0]      fill_nxt;
   logic [AW:0]      len_p1;
   logic [AW-1:0]    tap_addr;
   logic [WIDTH-1:0] tap_word;
   logic [WIDTH-1:0] last_word;
   logic [WIDTH-1:0] y_q;
   logic             valid_q;

   // Tap address wraps to DEPTH-1 when len_q is 0; that path is unused
   // because the bypass mux selects d directly in that case.
   assign len_p1   = {1'b0, len_q} + (AW+1)'(1);
   assign tap_addr = len_q - AW'(1);

   srl_store #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_store (
      .clk  (clk),
      .ce   (bus.ce),
      .d    (bus.d),
      .addr (tap_addr),
      .tap  (tap_word),
      .last (last_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q <= AW'(LEN_RST);
      end else if (bus.len_ld) begin
         len_q <= bus.len;
      end
   end

   // A load discards the strobe it coincides with; otherwise count
   // strobes up to the current delay and hold there.
   always_comb begin
      fill_nxt = fill;
      if (bus.len_ld) begin
         fill_nxt = '0;
      end else if (bus.ce && (fill != len_p1)) begin
         fill_nxt = fill + (AW+1)'(1);
      end
   end

   // valid looks at the next fill value so it rises on the same edge that
   // brings the first post-load word onto y.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill    <= '0;
         valid_q <= 1'b0;
      end else begin
         fill    <= fill_nxt;
         valid_q <= (fill_nxt == len_p1);
      end
   end

   // Output register reads pre-shift storage, so mem[len_q-1] is the word
   // accepted len_q strobes ago; a zero length bypasses storage entirely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q <= '0;
      end else if (bus.ce) begin
         y_q <= (len_q == '0) ? bus.d : tap_word;
      end
   end

   assign bus.y     = y_q;
   assign bus.valid = valid_q;
   assign bus.yc    = last_word;

endmodule

// File: tb/tb_srl_delay_line.sv
// Self-checking bench for srl_delay_line: a 4x32 instance driven through a
// scoreboard fed by a behavioural history model, plus an 8x16 instance
// exercising the cascade tap.
module tb_srl_delay_line;

   logic clk;
   logic rst;

   int checks;
   int errors;
   int step;

   srl_delay_line_if #(.WIDTH(4), .DEPTH(32)) bus1 ();
   srl_delay_line_if #(.WIDTH(8), .DEPTH(16)) bus2 ();

   srl_delay_line #(.WIDTH(4), .DEPTH(32), .LEN_RST(31)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   srl_delay_line #(.WIDTH(8), .DEPTH(16), .LEN_RST(15)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] y;
      logic       valid;
      logic [3:0] yc;
      logic       chk_y;
      logic       chk_yc;
   } sb_t;

   sb_t        sb [$];
   logic [3:0] hist [$];
   int         mlen;
   int         mfill;
   logic [3:0] my;
   logic       my_known;
   logic       mvalid;
   logic [3:0] dv;

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s step %0d: observed 0x%0h expected 0x%0h", tag, step, obs, exp);
      end
   endtask

   task automatic checkOutput();
      sb_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty step %0d: observed 0 entries expected 1", step);
         return;
      end
      e = sb.pop_front();
      checkValue("valid", 32'(bus1.valid), 32'(e.valid));
      if (e.chk_y)  checkValue("y",  32'(bus1.y),  32'(e.y));
      if (e.chk_yc) checkValue("yc", 32'(bus1.yc), 32'(e.yc));
   endtask

   // Drive one cycle on the 4x32 instance, predict its post-edge outputs
   // from the word history, then compare just after the edge.
   task automatic applyStimulus(input logic ce_v, input logic [3:0] d_v,
                                input logic ld_v, input logic [4:0] len_v);
      sb_t e;
      bus1.ce     = ce_v;
      bus1.d      = d_v;
      bus1.len_ld = ld_v;
      bus1.len    = len_v;
      if (ce_v) begin
         if (mlen == 0) begin
            my       = d_v;
            my_known = 1'b1;
         end else if (hist.size() >= mlen) begin
            my       = hist[hist.size() - mlen];
            my_known = 1'b1;
         end else begin
            my_known = 1'b0;
         end
         hist.push_back(d_v);
      end
      if (ld_v) mfill = 0;
      else if (ce_v && mfill < mlen + 1) mfill++;
      mvalid = !ld_v && (mfill == mlen + 1);
      if (ld_v) mlen = int'(len_v);
      e.y      = my;
      e.valid  = mvalid;
      e.chk_y  = my_known;
      e.chk_yc = (hist.size() >= 32);
      e.yc     = e.chk_yc ? hist[hist.size() - 32] : 4'h0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
      step++;
   endtask

   task automatic modelReset();
      mfill    = 0;
      mvalid   = 1'b0;
      my       = 4'h0;
      my_known = 1'b1;
      mlen     = 31;
   endtask

   task automatic strobeWide(input logic ce_v, input logic [7:0] d_v,
                             input logic ld_v, input logic [3:0] len_v);
      bus2.ce     = ce_v;
      bus2.d      = d_v;
      bus2.len_ld = ld_v;
      bus2.len    = len_v;
      @(posedge clk);
      #1;
      step++;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      step   = 0;
      dv     = 4'h0;
      rst    = 1'b1;
      bus1.ce = 1'b0; bus1.d = '0; bus1.len = '0; bus1.len_ld = 1'b0;
      bus2.ce = 1'b0; bus2.d = '0; bus2.len = '0; bus2.len_ld = 1'b0;
      modelReset();

      repeat (2) @(posedge clk);
      #1;
      checkValue("reset_y", 32'(bus1.y), 32'h0);
      checkValue("reset_valid", 32'(bus1.valid), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] continuous stream at reset length 31");
      for (int i = 0; i < 40; i++) begin
         dv = dv + 4'h1;
         applyStimulus(1'b1, dv, 1'b0, 5'd0);
      end

      $display("[TB] zero-length bypass");
      applyStimulus(1'b0, 4'h0, 1'b1, 5'd0);
      applyStimulus(1'b1, 4'hA, 1'b0, 5'd0);
      applyStimulus(1'b1, 4'h5, 1'b0, 5'd0);

      $display("[TB] length 3 with gapped strobes");
      applyStimulus(1'b0, 4'h0, 1'b1, 5'd3);
      for (int i = 0; i < 12; i++) begin
         dv = dv + 4'h3;
         applyStimulus(i[0] == 1'b0, dv, 1'b0, 5'd0);
      end

      $display("[TB] length 7 load coinciding with a strobe");
      for (int i = 0; i < 3; i++) begin
         dv = dv + 4'h1;
         applyStimulus(1'b1, dv, 1'b0, 5'd0);
      end
      dv = dv + 4'h1;
      applyStimulus(1'b1, dv, 1'b1, 5'd7);
      for (int i = 0; i < 12; i++) begin
         dv = dv + 4'h5;
         applyStimulus(1'b1, dv, 1'b0, 5'd0);
      end

      $display("[TB] asynchronous reset mid-stream");
      bus1.ce = 1'b0;
      bus1.len_ld = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkValue("async_rst_y", 32'(bus1.y), 32'h0);
      checkValue("async_rst_valid", 32'(bus1.valid), 32'h0);
      modelReset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 35; i++) begin
         dv = dv + 4'h7;
         applyStimulus(1'b1, dv, 1'b0, 5'd0);
      end

      $display("[TB] 8x16 cascade tap");
      strobeWide(1'b0, 8'h00, 1'b1, 4'd5);
      for (int k = 1; k <= 16; k++) begin
         strobeWide(1'b1, 8'(8'h0F + k), 1'b0, 4'd0);
         checkValue("wide_valid", 32'(bus2.valid), 32'(k >= 6));
         if (k >= 6) checkValue("wide_y", 32'(bus2.y), 32'(8'h10 + k - 6));
      end
      checkValue("wide_yc", 32'(bus2.yc), 32'h10);
      checkValue("wide_y_final", 32'(bus2.y), 32'h1A);
      bus2.ce = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/srl_delay_line.md
# srl_delay_line

Parametrised, programmable-length delay line; generalises the fixed 32×4 SRL shift register to arbitrary word width and power-of-two depth. Adds a registered output, a load strobe for length changes, a fill tracker that flags when the output carries data entered since the last reset or length change, and a fixed-depth cascade tap. It sits in the DSP datapath wherever matched delays are needed, such as I/Q alignment and filter tap alignment. The storage array has no reset so that it maps to SRL primitives.

## Interface
- WIDTH, 4: word width in bits (≥1).
- DEPTH, 32: maximum delay in ce strobes; power of two, ≥2.
- AW, log2(DEPTH): length-field width (derived).
- LEN_RST, DEPTH-1: length code applied at reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  shift enable; one word accepted per cycle with ce=1.
- d  in  WIDTH  input word.
- len  in  AW  requested length code L; delay = L+1 ce strobes.
- len_ld  in  1  load strobe; samples len into len_q.
- y  out  WIDTH  registered delayed word.
- valid  out  1  y holds a word accepted since the last reset or length load.
- yc  out  WIDTH  cascade tap, oldest stored word, fixed delay DEPTH (combinational from storage).

## Operation
- Storage mem[0..DEPTH-1]. On ce: mem[0]<=d, mem[i]<=mem[i-1]. No reset.
- Output register: on ce, y <= (len_q==0) ? d : mem[len_q-1]. This uses pre-shift values, so a word accepted on ce strobe k appears on y after strobe k+len_q. Total delay is len_q+1 strobes.
- y holds its value when ce=0.
- yc = mem[DEPTH-1].
- len_q: loaded from len on any clock with len_ld=1, independent of ce.
- fill counter, AW+1 bits:
  - cleared on rst or len_ld;
  - otherwise incremented on ce;
  - saturates at len_q+1.
- valid = (fill == len_q+1), registered.
- Simultaneous len_ld and ce:
  - the shift and the y update still occur, using the old len_q;
  - fill is cleared, so that strobe is not counted;
  - valid becomes 0 on the next clock.
- len_ld with len equal to len_q still clears fill and valid, so it acts as a flush of the valid flag.
- Reset mid-stream: y, valid and fill clear immediately and asynchronously. Storage contents are retained but treated as stale.

## Timing
- Reset values: y=0, valid=0, fill=0, len_q=LEN_RST. yc is undefined until DEPTH ce strobes have occurred.
- After reset or len_ld, valid rises on the clock edge of the (len_q+1)th subsequent ce strobe. From that edge, y equals the first word accepted after the load.
- ce-to-y latency is len_q+1 strobes. Idle cycles (ce=0) do not advance any state except the len_q load.
- Changing len_q without len_ld has no effect; len is don't-care when len_ld=0.
- Deassertion of rst is expected synchronous to clk; the block does not synchronise it internally.

## Structure
- Shared package srl_pkg holds:
  - function clog2 (used to derive AW);
  - a localparam check that DEPTH is a power of two and at least 2.
- Sub-module srl_store(WIDTH, DEPTH):
  - contains the reset-free shift array only;
  - ports clk, ce, d, tap address, tap output, last output.
- srl_delay_line contains:
  - len_q;
  - the fill counter with its saturation logic;
  - the valid register;
  - the output register;
  - the len_q==0 bypass mux.

## Test plan
- Reset then ce=1 continuously with d=1,2,3,… and LEN_RST=31: valid rises on the 32nd strobe edge, with y=1 at that edge and y=2 at the next.
- len=0 with len_ld, then ce=1 and d=0xA then 0x5: y=0xA and valid=1 after one strobe; y=0x5 after the next.
- len=3 loaded, ce toggled 1,0,1,0,…: y and valid advance only on ce strobes; valid rises on the 4th strobe.
- len_ld with len=7 asserted on the same cycle as a ce strobe, mid-stream: valid drops next clock and re-rises exactly 8 strobes later; y carries the word accepted on the strobe after the load.
- rst pulsed mid-stream between clock edges: y=0 and valid=0 immediately. After release, valid stays low until len_q+1 new strobes.
- WIDTH=8, DEPTH=16, 16 strobes with d=0x10..0x1F: yc=0x10 after the 16th strobe; y tracks len_q independently.
